riscv_prefetch_req_ctrl: RTL

Instruction-memory initiator that produces the write side of the fetch FIFO. It issues word-aligned requests on the instruction bus with a req/gnt/rvalid handshake, one transaction outstanding. It pushes each returned word into the FIFO with its address, and drives the FIFO's clear, replace2 and is_hwlp controls on branches and hardware-loop redirects. It sits between the core's PC/hwloop logic and the fetch FIFO inside the IF stage.

---
 rtl/riscv_prefetch_pkg.sv | 30 +++
 rtl/riscv_prefetch_req_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_prefetch_pkg.sv
// ---------------------------------------------------------------------------
// riscv_prefetch_pkg
//
// Purpose: shared definitions for the instruction prefetch request
//          controller: FSM state encoding and the sequential word increment.
//
// Contents:
//   state_t       - 2-bit state type
//   IDLE          - no transaction
//   WAIT_GNT      - request raised, waiting for the bus grant
//   WAIT_RVALID   - granted, waiting for the response word
//   WAIT_ABORTED  - granted, but a branch made the response stale
//   WORD_INCR     - byte increment between consecutive fetch words
//
// Optional feature macro used by importers: RISCV_PREFETCH_HWLP_EN
// ---------------------------------------------------------------------------
package riscv_prefetch_pkg;

  // Plain constants rather than an enum type keeps the encoding visible to
  // older tools and lets the state be compared against raw 2-bit values.
  typedef logic [1:0] state_t;

  localparam state_t IDLE         = 2'd0;
  localparam state_t WAIT_GNT     = 2'd1;
  localparam state_t WAIT_RVALID  = 2'd2;
  localparam state_t WAIT_ABORTED = 2'd3;

  localparam int unsigned WORD_INCR = 4;

endpackage : riscv_prefetch_pkg

// File: rtl/riscv_prefetch_req_ctrl.sv
// ---------------------------------------------------------------------------
// riscv_prefetch_req_ctrl
//
// Purpose: instruction-memory initiator feeding the write side of the fetch
//          FIFO. Issues word-aligned requests with a req/gnt/rvalid
//          handshake (one transaction outstanding), pushes each returned
//          word into the FIFO together with its address, and drives the
//          FIFO clear / replace2 / is_hwlp controls on branches and
//          hardware-loop redirects.
//
// Optional feature: RISCV_PREFETCH_HWLP_EN
//   defined   - hwloop_i redirects the next fetch to hwloop_target_i and the
//               resulting word is pushed with replace2/is_hwlp set.
//   undefined - hardware-loop logic is absent; hwloop_i/hwloop_target_i are
//               ignored and replace2/is_hwlp are tied to 0.
//
// Ports:
//   clk              clock
//   rst_n            synchronous active-low reset
//   req_i            fetching enabled
//   branch_i         redirect pulse, target on branch_addr_i
//   branch_addr_i    branch target (bit 1 may be set)
//   hwloop_i         pulse: next fetch goes to hwloop_target_i
//   hwloop_target_i  hardware-loop start address
//   instr_req_o      bus request
//   instr_addr_o     bus address, always word aligned
//   instr_gnt_i      bus grant
//   instr_rvalid_i   response valid
//   instr_rdata_i    response data
//   fifo_valid_o     FIFO push strobe
//   fifo_addr_o      address of the pushed word
//   fifo_rdata_o     pushed data
//   fifo_ready_i     FIFO can take one more request's data
//   fifo_clear_o     invalidate FIFO contents
//   fifo_replace2_o  pushed word replaces FIFO entry 1
//   fifo_is_hwlp_o   pushed word is a hardware-loop target
//   busy_o           transaction in flight or requesting
// ---------------------------------------------------------------------------
module riscv_prefetch_req_ctrl
  import riscv_prefetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  input  logic                  hwloop_i,
  input  logic [ADDR_WIDTH-1:0] hwloop_target_i,

  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,

  output logic                  fifo_valid_o,
  output logic [ADDR_WIDTH-1:0] fifo_addr_o,
  output logic [DATA_WIDTH-1:0] fifo_rdata_o,
  input  logic                  fifo_ready_i,
  output logic                  fifo_clear_o,
  output logic                  fifo_replace2_o,
  output logic                  fifo_is_hwlp_o,

  output logic                  busy_o
);

  // -------------------------------------------------------------------------
  // State and registers
  // -------------------------------------------------------------------------
  state_t                  state_reg, state_next;
  // Address of the next word to request. Keeps bit 1 of a redirect target so
  // that the first pushed word after the redirect reports the halfword offset.
  logic [ADDR_WIDTH-1:0]   fetch_addr_reg, fetch_addr_next;
  // Full (unaligned) address of the granted transaction, reported on push.
  logic [ADDR_WIDTH-1:0]   txn_addr_reg, txn_addr_next;

  // -------------------------------------------------------------------------
  // Request-side decode
  // -------------------------------------------------------------------------
  logic                    hwlp_now;    // hwloop pulse that takes effect now
  logic [ADDR_WIDTH-1:0]   cur_addr;    // address the bus request would use
  logic [ADDR_WIDTH-1:0]   req_addr;    // word-aligned copy of cur_addr
  logic                    can_issue;
  logic                    rsp_state;
  logic                    issue;
  logic                    granted;
  logic                    push;

  // A branch or hwloop redirect overrides the stored fetch address in the
  // same cycle, so a request raised (or held in WAIT_GNT) switches target
  // without losing a cycle. Branch has priority over hwloop.
  assign cur_addr  = branch_i ? branch_addr_i
                   : (hwlp_now ? hwloop_target_i : fetch_addr_reg);
  assign req_addr  = {cur_addr[ADDR_WIDTH-1:2], 2'b00};

  assign can_issue = req_i & fifo_ready_i;
  assign rsp_state = (state_reg == WAIT_RVALID) || (state_reg == WAIT_ABORTED);

  // New requests start from IDLE, or back-to-back in the cycle the
  // outstanding response returns (one transaction outstanding at a time).
  assign issue     = can_issue &
                     ((state_reg == IDLE) | (rsp_state & instr_rvalid_i));

  // Once raised, the request is held until granted regardless of req_i or
  // fifo_ready_i.
  assign instr_req_o  = issue | (state_reg == WAIT_GNT);
  assign instr_addr_o = req_addr;
  assign granted      = instr_req_o & instr_gnt_i;

  // A branch in the same cycle as the response makes that word stale.
  // fifo_ready_i is deliberately not consulted: the FIFO reserves a slot
  // for the word of any request it allowed to issue.
  assign push         = (state_reg == WAIT_RVALID) & instr_rvalid_i & ~branch_i;

  assign fifo_valid_o = push;
  assign fifo_addr_o  = push ? txn_addr_reg  : '0;
  assign fifo_rdata_o = push ? instr_rdata_i : '0;
  assign fifo_clear_o = branch_i;

  assign busy_o       = (state_reg != IDLE) | instr_req_o;

  // -------------------------------------------------------------------------
  // Hardware-loop redirect
  // -------------------------------------------------------------------------
`ifdef RISCV_PREFETCH_HWLP_EN
  // hwlp_pend_reg: a hwloop redirect is stored in fetch_addr_reg and still
  //                waiting for its request to be granted.
  // pend_hwlp_word_reg: the granted (outstanding) transaction is the loop
  //                target word.
  logic hwlp_pend_reg, hwlp_pend_next;
  logic pend_hwlp_word_reg, pend_hwlp_word_next;
  logic cur_hwlp;

  assign hwlp_now = hwloop_i & ~branch_i;
  // The current request is a loop-target fetch if the redirect arrives now
  // or was stored earlier and not yet granted.
  assign cur_hwlp = ~branch_i & (hwloop_i | hwlp_pend_reg);

  always_comb begin
    hwlp_pend_next      = hwlp_pend_reg;
    pend_hwlp_word_next = pend_hwlp_word_reg;
    if (branch_i) begin
      hwlp_pend_next      = 1'b0;
      pend_hwlp_word_next = 1'b0;
    end else if (hwloop_i) begin
      hwlp_pend_next      = 1'b1;
    end
    // The grant consumes any pending redirect and tags the transaction.
    if (granted) begin
      hwlp_pend_next      = 1'b0;
      pend_hwlp_word_next = cur_hwlp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hwlp_pend_reg      <= 1'b0;
      pend_hwlp_word_reg <= 1'b0;
    end else begin
      hwlp_pend_reg      <= hwlp_pend_next;
      pend_hwlp_word_reg <= pend_hwlp_word_next;
    end
  end

  assign fifo_replace2_o = push & pend_hwlp_word_reg;
  assign fifo_is_hwlp_o  = push & pend_hwlp_word_reg;
`else
  // Ports stay for interface compatibility; the loop inputs have no effect.
  logic unused_hwlp_in;
  assign unused_hwlp_in  = hwloop_i;
  assign hwlp_now        = 1'b0;
  assign fifo_replace2_o = 1'b0;
  assign fifo_is_hwlp_o  = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (granted) begin
      state_next = WAIT_RVALID;
    end else if (instr_req_o) begin
      state_next = WAIT_GNT;
    end else begin
      case (state_reg)
        IDLE:         state_next = IDLE;
        WAIT_GNT:     state_next = WAIT_GNT;
        WAIT_RVALID: begin
          if (instr_rvalid_i)
            state_next = IDLE;
          else if (branch_i)
            state_next = WAIT_ABORTED;
          else
            state_next = WAIT_RVALID;
        end
        WAIT_ABORTED: state_next = instr_rvalid_i ? IDLE : WAIT_ABORTED;
        default:      state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    fetch_addr_next = fetch_addr_reg;
    txn_addr_next   = txn_addr_reg;
    // Redirects are remembered even when no request goes out this cycle.
    if (branch_i)
      fetch_addr_next = branch_addr_i;
    else if (hwlp_now)
      fetch_addr_next = hwloop_target_i;
    // On grant the next word follows the one just granted; the granted
    // address keeps its bit 1 for the push.
    if (granted) begin
      fetch_addr_next = req_addr + ADDR_WIDTH'(WORD_INCR);
      txn_addr_next   = cur_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      fetch_addr_reg <= '0;
      txn_addr_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_addr_reg <= fetch_addr_next;
      txn_addr_reg   <= txn_addr_next;
    end
  end

endmodule : riscv_prefetch_req_ctrl
